// File: rtl/reg_status_file_pkg.sv
// Shared widths and types for the architectural register status file.
// The project-wide width macros normally come from info.v; the guards keep
// any definition already supplied by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_LR_WIDTH
`define ROB_LR_WIDTH 4
`endif
`ifndef MaxROB
`define MaxROB 16
`endif

package reg_status_file_pkg;
  localparam int DATA_W  = `DATA_WIDTH;
  localparam int ROB_W   = `ROB_LR_WIDTH;
  localparam int MAX_ROB = `MaxROB;
  localparam int NREG    = 32;
  localparam int IDX_W   = 5;
  localparam int NUM_RD  = 2;

  // One architectural register: pending-producer flag, owning ROB tag, value.
  typedef struct packed {
    logic              busy;
    logic [ROB_W-1:0]  reorder;
    logic [DATA_W-1:0] value;
  } reg_stat_t;
endpackage

// File: rtl/reg_status_file_if.sv
// Issue / commit / lookup bundle between the core pipeline and the
// register status file.
interface reg_status_file_if;
  import reg_status_file_pkg::*;

  logic [IDX_W-1:0]  issue_rs1, issue_rs2;
  logic              rs1_busy, rs2_busy;
  logic [ROB_W-1:0]  rs1_reorder, rs2_reorder;
  logic [DATA_W-1:0] rs1_value, rs2_value;

  logic              issue_rd_valid;
  logic [IDX_W-1:0]  issue_rd;
  logic [ROB_W-1:0]  issue_tag;

  logic              commit_valid;
  logic              commit_clear;
  logic [DATA_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_value;

  logic              reg_busy_commit_rd;
  logic [ROB_W-1:0]  reg_reorder_commit_rd;
  logic [31:0]       commit_count;

  modport master (
    output issue_rs1, issue_rs2, issue_rd_valid, issue_rd, issue_tag,
           commit_valid, commit_clear, commit_rd, commit_value,
    input  rs1_busy, rs2_busy, rs1_reorder, rs2_reorder, rs1_value, rs2_value,
           reg_busy_commit_rd, reg_reorder_commit_rd, commit_count
  );

  modport slave (
    input  issue_rs1, issue_rs2, issue_rd_valid, issue_rd, issue_tag,
           commit_valid, commit_clear, commit_rd, commit_value,
    output rs1_busy, rs2_busy, rs1_reorder, rs2_reorder, rs1_value, rs2_value,
           reg_busy_commit_rd, reg_reorder_commit_rd, commit_count
  );
endinterface

// File: rtl/reg_status_file_read_port.sv
// Combinational source-operand lookup with commit-to-read forwarding.
module reg_read_port
  import reg_status_file_pkg::*;
(
  input  reg_stat_t [NREG-1:0] rf,
  input  logic [IDX_W-1:0]     idx,
  input  logic                 byp_en,
  input  logic [IDX_W-1:0]     byp_rd,
  input  logic [DATA_W-1:0]    byp_value,
  output reg_stat_t            stat
);

  // A clearing commit to the same register resolves the dependency in the
  // same cycle; the tag is left as registered since it no longer matters.
  always_comb begin
    stat = rf[idx];
    if (byp_en && (byp_rd == idx) && (idx != '0)) begin
      stat.busy  = 1'b0;
      stat.value = byp_value;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register status file: per-register value / busy / ROB tag,
// renamed at issue, resolved at commit, flushed on mispredict.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              Clear_flag,
  reg_status_file_if.slave  bus
);

  logic [IDX_W-1:0] crd;
  logic             unused_commit_rd_hi;
  logic             commit_go, issue_go, clear_go, byp_en;
  reg_stat_t [NREG-1:0] rf;
  logic [31:0]      count_q;

  assign crd                 = bus.commit_rd[IDX_W-1:0];
  assign unused_commit_rd_hi = ^bus.commit_rd[DATA_W-1:IDX_W];

  assign clear_go  = rdy && Clear_flag;
  assign commit_go = rdy && !Clear_flag && bus.commit_valid;
  assign issue_go  = rdy && !Clear_flag && bus.issue_rd_valid;
  // Forwarding ignores rdy: the read ports always show what a commit would write.
  assign byp_en    = bus.commit_valid && bus.commit_clear && !Clear_flag;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign rf[r] = '0;
    end else begin : g_live
      localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(r);
      reg_stat_t q;
      logic      commit_hit, issue_hit;

      assign commit_hit = commit_go && (crd == MY_IDX);
      assign issue_hit  = issue_go && (bus.issue_rd == MY_IDX);

      // Issue is applied after commit so a same-cycle rename keeps the register busy.
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (clear_go) begin
          q.busy    <= 1'b0;
          q.reorder <= '0;
        end else begin
          if (commit_hit) begin
            q.value <= bus.commit_value;
            if (bus.commit_clear) q.busy <= 1'b0;
          end
          if (issue_hit) begin
            q.busy    <= 1'b1;
            q.reorder <= bus.issue_tag;
          end
        end
      end

      assign rf[r] = q;
    end
  end

  logic [NUM_RD-1:0][IDX_W-1:0] rs_idx;
  reg_stat_t [NUM_RD-1:0]       rs_stat;

  assign rs_idx = {bus.issue_rs2, bus.issue_rs1};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    reg_read_port u_rp (
      .rf        (rf),
      .idx       (rs_idx[g]),
      .byp_en    (byp_en),
      .byp_rd    (crd),
      .byp_value (bus.commit_value),
      .stat      (rs_stat[g])
    );
  end

  assign bus.rs1_busy    = rs_stat[0].busy;
  assign bus.rs1_reorder = rs_stat[0].reorder;
  assign bus.rs1_value   = rs_stat[0].value;
  assign bus.rs2_busy    = rs_stat[1].busy;
  assign bus.rs2_reorder = rs_stat[1].reorder;
  assign bus.rs2_value   = rs_stat[1].value;

  // ROB ownership lookup uses registered state only so it cannot loop back
  // through the commit inputs.
  assign bus.reg_busy_commit_rd    = rf[crd].busy;
  assign bus.reg_reorder_commit_rd = rf[crd].reorder;

  // Accepted commits, x0 included; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)            count_q <= '0;
    else if (commit_go) count_q <= count_q + 32'd1;
  end

  assign bus.commit_count = count_q;

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: table of per-cycle vectors with hand-derived
// expectations, queued on drive and checked at the falling edge.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, Clear_flag;
  reg_status_file_if bus();

  reg_status_file dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .Clear_flag (Clear_flag),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              chk;
    logic              rst;
    logic              rdy;
    logic              clr;
    logic [4:0]        rs1, rs2;
    logic              iv;
    logic [4:0]        ird;
    logic [ROB_W-1:0]  tag;
    logic              cv, cc;
    logic [4:0]        crd;
    logic [31:0]       cval;
    logic              eb1;
    logic [ROB_W-1:0]  er1;
    logic [31:0]       ev1;
    logic              eb2;
    logic [ROB_W-1:0]  er2;
    logic [31:0]       ev2;
    logic              ecb;
    logic [ROB_W-1:0]  ecr;
    logic [31:0]       ecnt;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t tbl[$];
  logic [31:0] vals [NREG];

  function automatic vec_t mk(
    input string nm, input logic rdy_i, input logic clr_i,
    input logic [4:0] rs1_i, input logic [4:0] rs2_i,
    input logic iv_i, input logic [4:0] ird_i, input logic [ROB_W-1:0] tag_i,
    input logic cv_i, input logic cc_i, input logic [4:0] crd_i, input logic [31:0] cval_i,
    input logic eb1_i, input logic [ROB_W-1:0] er1_i, input logic [31:0] ev1_i,
    input logic eb2_i, input logic [ROB_W-1:0] er2_i, input logic [31:0] ev2_i,
    input logic ecb_i, input logic [ROB_W-1:0] ecr_i, input logic [31:0] ecnt_i);
    vec_t v;
    v.name = nm; v.chk = 1'b1; v.rst = 1'b0; v.rdy = rdy_i; v.clr = clr_i;
    v.rs1 = rs1_i; v.rs2 = rs2_i; v.iv = iv_i; v.ird = ird_i; v.tag = tag_i;
    v.cv = cv_i; v.cc = cc_i; v.crd = crd_i; v.cval = cval_i;
    v.eb1 = eb1_i; v.er1 = er1_i; v.ev1 = ev1_i;
    v.eb2 = eb2_i; v.er2 = er2_i; v.ev2 = ev2_i;
    v.ecb = ecb_i; v.ecr = ecr_i; v.ecnt = ecnt_i;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check before the edge.
  task automatic run(input vec_t v);
    vec_t e;
    rst                = v.rst;
    rdy                = v.rdy;
    Clear_flag         = v.clr;
    bus.issue_rs1      = v.rs1;
    bus.issue_rs2      = v.rs2;
    bus.issue_rd_valid = v.iv;
    bus.issue_rd       = v.ird;
    bus.issue_tag      = v.tag;
    bus.commit_valid   = v.cv;
    bus.commit_clear   = v.cc;
    bus.commit_rd      = {27'h2AAAAAA, v.crd};
    bus.commit_value   = v.cval;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if (e.chk) begin
        chk({e.name, ".rs1_busy"},    32'(bus.rs1_busy),              32'(e.eb1));
        chk({e.name, ".rs1_reorder"}, 32'(bus.rs1_reorder),           32'(e.er1));
        chk({e.name, ".rs1_value"},   bus.rs1_value,                  e.ev1);
        chk({e.name, ".rs2_busy"},    32'(bus.rs2_busy),              32'(e.eb2));
        chk({e.name, ".rs2_reorder"}, 32'(bus.rs2_reorder),           32'(e.er2));
        chk({e.name, ".rs2_value"},   bus.rs2_value,                  e.ev2);
        chk({e.name, ".cmt_busy"},    32'(bus.reg_busy_commit_rd),    32'(e.ecb));
        chk({e.name, ".cmt_reorder"}, 32'(bus.reg_reorder_commit_rd), 32'(e.ecr));
        chk({e.name, ".commit_count"}, bus.commit_count,              e.ecnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //              name               rdy  clr  rs1 rs2 iv ird tag  cv cc crd cval            b1 r1 v1            b2 r2 v2            cb cr cnt
    tbl.push_back(mk("reset_x5",        1, 0,  5, 0, 0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd0));
    tbl.push_back(mk("issue5",          1, 0,  5, 5, 1, 5, 3,   0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd0));
    tbl.push_back(mk("commit5_bypass",  1, 0,  5, 6, 0, 0, 0,   1, 1, 5, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 0, 0, 32'h0,        1, 3, 32'd0));
    tbl.push_back(mk("after_commit5",   1, 0,  5, 0, 0, 0, 0,   0, 0, 5, 32'h0,        0, 3, 32'hDEADBEEF, 0, 0, 32'h0,        0, 3, 32'd1));
    tbl.push_back(mk("issue7_t2",       1, 0,  7, 0, 1, 7, 2,   0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd1));
    tbl.push_back(mk("issue7_t4",       1, 0,  7, 0, 1, 7, 4,   0, 0, 7, 32'h0,        1, 2, 32'h0,        0, 0, 32'h0,        1, 2, 32'd1));
    tbl.push_back(mk("commit7_keep",    1, 0,  7, 0, 0, 0, 0,   1, 0, 7, 32'd9,        1, 4, 32'h0,        0, 0, 32'h0,        1, 4, 32'd1));
    tbl.push_back(mk("check7",          1, 0,  7, 5, 0, 0, 0,   0, 0, 7, 32'h0,        1, 4, 32'd9,        0, 3, 32'hDEADBEEF, 1, 4, 32'd2));
    tbl.push_back(mk("issue_commit8",   1, 0,  8, 0, 1, 8, 6,   1, 1, 8, 32'h55,       0, 0, 32'h55,       0, 0, 32'h0,        0, 0, 32'd2));
    tbl.push_back(mk("check8",          1, 0,  8, 0, 0, 0, 0,   0, 0, 8, 32'h0,        1, 6, 32'h55,       0, 0, 32'h0,        1, 6, 32'd3));
    tbl.push_back(mk("x0_write",        1, 0,  0, 0, 1, 0, 5,   1, 1, 0, 32'h1234,     0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd3));
    tbl.push_back(mk("x0_check",        1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd4));
    tbl.push_back(mk("rdy0_commit",     0, 0,  9,10, 1,10, 7,   1, 1, 9, 32'hAAAA,     0, 0, 32'hAAAA,     0, 0, 32'h0,        0, 0, 32'd4));
    tbl.push_back(mk("rdy0_check",      1, 0,  9,10, 0, 0, 0,   0, 0,10, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd4));
    tbl.push_back(mk("commit3",         1, 0,  3, 0, 0, 0, 0,   1, 0, 3, 32'h33,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'd4));

    foreach (vals[i]) vals[i] = 32'h0;
    vals[3] = 32'h33; vals[5] = 32'hDEADBEEF; vals[7] = 32'd9; vals[8] = 32'h55;

    rst = 1'b1; rdy = 1'b1; Clear_flag = 1'b0;
    bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_rd_valid = 1'b0;
    bus.issue_rd = '0; bus.issue_tag = '0; bus.commit_valid = 1'b0;
    bus.commit_clear = 1'b0; bus.commit_rd = '0; bus.commit_value = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Rename every register to a tag equal to its low index bits.
    for (int r = 1; r < NREG; r++) begin
      v = mk("issue_all", 1, 0, 5'(r), 0, 1, 5'(r), ROB_W'(r), 0, 0, 0, 32'h0,
             0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'd5);
      v.chk = 1'b0;
      run(v);
    end

    // Flush request while stalled must not take effect.
    run(mk("rdy0_clear", 0, 1, 3, 0, 0, 0, 0, 0, 0, 3, 32'h0,
           1, 3, 32'h33, 0, 0, 32'h0, 1, 3, 32'd5));

    for (int r = 1; r < NREG; r++)
      run(mk("busy_sweep", 1, 0, 5'(r), 5'(r), 0, 0, 0, 0, 0, 5'(r), 32'h0,
             1, ROB_W'(r), vals[r], 1, ROB_W'(r), vals[r], 1, ROB_W'(r), 32'd5));

    // Flush with a concurrent commit and issue: both are dropped, no forwarding.
    run(mk("clear_commit3", 1, 1, 3, 4, 1, 4, '1, 1, 1, 3, 32'h77,
           1, 3, 32'h33, 1, 4, 32'h0, 1, 3, 32'd5));

    for (int r = 1; r < NREG; r++)
      run(mk("clear_sweep", 1, 0, 5'(r), 5'(r), 0, 0, 0, 0, 0, 5'(r), 32'h0,
             0, 0, vals[r], 0, 0, vals[r], 0, 0, 32'd5));

    // Reset beats stall, flush and the same-cycle issue/commit.
    v = mk("rst_midop", 0, 1, 5, 3, 1, 5, 2, 1, 1, 5, 32'hFFFF,
           0, 0, 32'hDEADBEEF, 0, 0, 32'h33, 0, 0, 32'd5);
    v.rst = 1'b1;
    run(v);
    run(mk("post_rst", 1, 0, 5, 3, 0, 0, 0, 0, 0, 5, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous active-high reset.
REQ-003 SHALL have port rdy  input  1  global enable; low = hold all state.
REQ-004 SHALL have port Clear_flag  input  1  mispredict flush, registered by cpu.v.
REQ-005 SHALL have ports issue_rs1, issue_rs2  input  5  source register indices from insqueue.
REQ-006 SHALL have ports rs1_busy, rs2_busy  output  1; rs1_reorder, rs2_reorder  output  `ROB_LR_WIDTH; rs1_value, rs2_value  output  `DATA_WIDTH  source status.
REQ-007 SHALL have ports issue_rd_valid  input  1; issue_rd  input  5; issue_tag  input  `ROB_LR_WIDTH  rename of dest to ROB entry.
REQ-008 SHALL have ports commit_valid  input  1 (ROB_to_Reg_needchange); commit_clear  input  1 (ROB_to_Reg_needchange2); commit_rd  input  `DATA_WIDTH, low 5 bits used; commit_value  input  `DATA_WIDTH.
REQ-009 SHALL have ports reg_busy_commit_rd  output  1; reg_reorder_commit_rd  output  `ROB_LR_WIDTH  status of commit_rd for ROB ownership check.
REQ-010 SHALL have port commit_count  output  32  number of accepted commits since reset.

Function
REQ-011 SHALL hold per register x1..x31: value (32b), busy (1b), reorder (`ROB_LR_WIDTH).
REQ-012 x0 SHALL read value 0, busy 0, reorder 0 always; issue and commit writes to x0 SHALL be ignored.
REQ-013 Read ports (rs1/rs2, commit_rd lookup) SHALL be combinational, zero latency.
REQ-014 rs read bypass: if commit_valid && commit_clear && commit_rd[4:0]==rsN && rsN!=0 && !Clear_flag, rsN_busy SHALL read 0 and rsN_value SHALL read commit_value; else registered state.
REQ-015 reg_busy_commit_rd/reg_reorder_commit_rd SHALL reflect registered state only (no bypass), to avoid combinational loop with ROB.
REQ-016 Commit (commit_valid, rdy, !Clear_flag): value[rd] <= commit_value next edge; if commit_clear, busy[rd] <= 0.
REQ-017 Issue (issue_rd_valid, rdy, !Clear_flag): busy[rd] <= 1, reorder[rd] <= issue_tag next edge.
REQ-018 Same-cycle issue and commit on same rd: value SHALL take commit_value; busy SHALL be 1 and reorder SHALL be issue_tag (issue wins).
REQ-019 Clear_flag=1 (rdy high): all busy <= 0, reorder <= 0; values retained; issue and commit inputs that cycle ignored.
REQ-020 rdy=0: no state change, including commit_count; outputs still combinationally valid.
REQ-021 commit_count SHALL increment by 1 per accepted commit (REQ-016 conditions, any rd incl. x0), wrap 2^32-1 -> 0.

Reset
REQ-022 On rst at clock edge: all values 0, busy 0, reorder 0, commit_count 0; rst overrides rdy and Clear_flag.
REQ-023 Reset mid-operation SHALL discard any same-cycle issue/commit.
REQ-024 All outputs after reset: rs*_busy 0, rs*_value 0, rs*_reorder 0, reg_busy_commit_rd 0, reg_reorder_commit_rd 0, commit_count 0.

Structure
REQ-025 `DATA_WIDTH, `ROB_LR_WIDTH, `MaxROB SHALL come from shared info.v; no local redefinition.
REQ-026 A sub-module reg_read_port (one instance per source, combinational lookup + bypass) is natural; otherwise flat.

Verification
REQ-027 Reset, then read x5 -> busy 0, value 0, commit_count 0.
REQ-028 Issue rd=5 tag=3; next cycle commit rd=5 value 0xDEADBEEF clear=1 with issue_rs1=5 -> same cycle rs1_busy 0, rs1_value 0xDEADBEEF; after edge busy[5]=0, commit_count 1.
REQ-029 Issue rd=7 tag=2, then issue rd=7 tag=4, then commit rd=7 clear=0 value 9 -> busy[7]=1, reorder 4, value 9.
REQ-030 Same cycle issue rd=8 tag=6 and commit rd=8 clear=1 value 0x55 -> busy 1, reorder 6, value 0x55.
REQ-031 Busy x1..x31 set, Clear_flag=1 with concurrent commit rd=3 -> all busy 0, value[3] unchanged, commit_count unchanged.
REQ-032 Issue/commit to rd=0 value 0x1234 -> x0 reads 0/busy 0, commit_count +1; rdy=0 with commit -> no change.
